// File: rtl/demux_lane_scheduler.sv
// Round-robin scheduler feeding a 4-bit 1:4 lane demux and assembling the 16-bit lane word.
// Partial words leave early on an explicit flush or after a programmable idle timeout.
module demux_lane_scheduler #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        inClock,
    input  logic        inResetN,
    input  logic [3:0]  inSymbol,
    input  logic        inSymbolValid,
    output logic        outSymbolReady,
    input  logic [3:0]  inLaneEnable,
    input  logic        inFlush,
    output logic [1:0]  outDemuxSel,
    output logic [3:0]  outDemuxData,
    output logic [15:0] outWord,
    output logic [3:0]  outWordMask,
    output logic        outWordValid,
    input  logic        inWordReady
);

    localparam int            TW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_r;
    logic            ready_r;
    logic            valid_r;
    logic [1:0]      sel_r;
    logic [3:0]      lane_mask_r;
    logic [15:0]     word_r;
    logic [3:0]      mask_r;
    logic [TW-1:0]   timer_r;

    logic            accept_s;
    logic [3:0]      above_s;
    logic            last_s;
    logic [3:0]      mask_next_s;
    logic [3:0]      demux_data_s;
    logic            expiry_s;

    function automatic logic [1:0] lowest_lane(input logic [3:0] m);
        logic [1:0] l;
        l = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) begin
                l = 2'(k);
            end else begin
                l = l;
            end
        end
        return l;
    endfunction

    // Enabled lanes strictly above s: shifting past bit 3 leaves an all-ones keep-out mask.
    function automatic logic [3:0] lanes_above(input logic [3:0] m, input logic [1:0] s);
        return m & ~((4'b0010 << s) - 4'd1);
    endfunction

    // Lane 0 sits in the top nibble, lane 3 in the bottom one.
    function automatic logic [15:0] lane_insert(input logic [15:0] w, input logic [1:0] s,
                                                input logic [3:0] d);
        logic [15:0] r;
        r = w;
        case (s)
            2'd0:    r[15:12] = d;
            2'd1:    r[11:8]  = d;
            2'd2:    r[7:4]   = d;
            default: r[3:0]   = d;
        endcase
        return r;
    endfunction

    // Accept decode, next-lane search and timeout detection for the current cycle.
    always_comb begin
        accept_s = inSymbolValid & ready_r;
        above_s  = lanes_above(lane_mask_r, sel_r);
        last_s   = (above_s == 4'd0);
        if (accept_s) begin
            mask_next_s  = mask_r | (4'd1 << sel_r);
            demux_data_s = inSymbol;
        end else begin
            mask_next_s  = mask_r;
            demux_data_s = 4'd0;
        end
        expiry_s = TIMEOUT_EN && (mask_r != 4'd0) && (timer_r >= TIMER_LAST);
    end

    // Frame FSM with registered handshake outputs.
    always_ff @(posedge inClock or negedge inResetN) begin
        if (!inResetN) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b0;
            valid_r     <= 1'b0;
            sel_r       <= 2'd0;
            lane_mask_r <= 4'd0;
            word_r      <= 16'd0;
            mask_r      <= 4'd0;
            timer_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (inLaneEnable != 4'd0) begin
                        lane_mask_r <= inLaneEnable;
                        sel_r       <= lowest_lane(inLaneEnable);
                        word_r      <= 16'd0;
                        mask_r      <= 4'd0;
                        timer_r     <= '0;
                        ready_r     <= 1'b1;
                        state_r     <= ST_FILL;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (accept_s) begin
                        // An accept always lands, even when a flush or expiry coincides.
                        word_r  <= lane_insert(word_r, sel_r, inSymbol);
                        mask_r  <= mask_next_s;
                        timer_r <= '0;
                        if (!last_s) begin
                            sel_r <= lowest_lane(above_s);
                        end else begin
                            sel_r <= sel_r;
                        end
                        if (last_s || inFlush) begin
                            ready_r <= 1'b0;
                            valid_r <= 1'b1;
                            state_r <= ST_HOLD;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end else if ((inFlush && (mask_r != 4'd0)) || expiry_s) begin
                        ready_r <= 1'b0;
                        valid_r <= 1'b1;
                        state_r <= ST_HOLD;
                    end else if ((mask_r != 4'd0) && (timer_r < TIMER_MAX)) begin
                        timer_r <= timer_r + TW'(1);
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                ST_HOLD: begin
                    if (inWordReady) begin
                        valid_r <= 1'b0;
                        word_r  <= 16'd0;
                        mask_r  <= 4'd0;
                        timer_r <= '0;
                        if (inLaneEnable != 4'd0) begin
                            lane_mask_r <= inLaneEnable;
                            sel_r       <= lowest_lane(inLaneEnable);
                            ready_r     <= 1'b1;
                            state_r     <= ST_FILL;
                        end else begin
                            state_r     <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    valid_r <= 1'b0;
                    word_r  <= 16'd0;
                    mask_r  <= 4'd0;
                    timer_r <= '0;
                end
            endcase
        end
    end

    assign outSymbolReady = ready_r;
    assign outWordValid   = valid_r;
    assign outWord        = word_r;
    assign outWordMask    = mask_r;
    assign outDemuxSel    = sel_r;
    assign outDemuxData   = demux_data_s;

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Self-checking bench for demux_lane_scheduler: directed scenarios plus randomized traffic
// checked against a frame-level reference model (lane list, written-lane table, idle counter).
module tb_demux_lane_scheduler;

    localparam int TO = 8;

    logic        inClock;
    logic        inResetN;
    logic [3:0]  inSymbol;
    logic        inSymbolValid;
    logic        outSymbolReady;
    logic [3:0]  inLaneEnable;
    logic        inFlush;
    logic [1:0]  outDemuxSel;
    logic [3:0]  outDemuxData;
    logic [15:0] outWord;
    logic [3:0]  outWordMask;
    logic        outWordValid;
    logic        inWordReady;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: 0 = idle, 1 = filling, 2 = holding a word
    int         m_phase;
    int         m_lanes[$];
    int         m_pos;
    logic [3:0] m_sym[4];
    bit         m_wr[4];
    int         m_idle;

    demux_lane_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .inClock        (inClock),
        .inResetN       (inResetN),
        .inSymbol       (inSymbol),
        .inSymbolValid  (inSymbolValid),
        .outSymbolReady (outSymbolReady),
        .inLaneEnable   (inLaneEnable),
        .inFlush        (inFlush),
        .outDemuxSel    (outDemuxSel),
        .outDemuxData   (outDemuxData),
        .outWord        (outWord),
        .outWordMask    (outWordMask),
        .outWordValid   (outWordValid),
        .inWordReady    (inWordReady)
    );

    initial inClock = 1'b0;
    always #5 inClock = ~inClock;

    task automatic tick();
        @(posedge inClock);
        #1;
    endtask

    task automatic do_reset();
        inResetN      = 1'b0;
        inSymbol      = 4'd0;
        inSymbolValid = 1'b0;
        inLaneEnable  = 4'd0;
        inFlush       = 1'b0;
        inWordReady   = 1'b0;
        tick();
        tick();
        inResetN = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        inResetN      = 1'b0;
        inSymbol      = 4'hF;
        inSymbolValid = 1'b1;
        inLaneEnable  = 4'd0;
        inFlush       = 1'b0;
        inWordReady   = 1'b0;
        #3;
        n_tests++; if (outSymbolReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", outSymbolReady); end
        n_tests++; if (outWordValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", outWordValid); end
        n_tests++; if (outWord !== 16'h0000) begin n_fail++; $display("FAIL reset_word got %h want 0000", outWord); end
        n_tests++; if (outWordMask !== 4'b0000) begin n_fail++; $display("FAIL reset_mask got %b want 0000", outWordMask); end
        n_tests++; if (outDemuxSel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", outDemuxSel); end
        n_tests++; if (outDemuxData !== 4'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", outDemuxData); end
        tick();
        tick();
        inResetN = 1'b1;
        tick();
        tick();
        n_tests++; if (outSymbolReady !== 1'b0) begin n_fail++; $display("FAIL idle_no_enable_ready got %b want 0", outSymbolReady); end
        inSymbolValid = 1'b0;
    endtask

    task automatic test_full_frame();
        int cnt;
        bit got;
        do_reset();
        inLaneEnable = 4'hF;
        tick();
        n_tests++; if (outSymbolReady !== 1'b1) begin n_fail++; $display("FAIL fill_entry_ready got %b want 1", outSymbolReady); end
        for (int i = 0; i < 4; i++) begin
            inSymbol      = 4'(4'hA + i);
            inSymbolValid = 1'b1;
            #1;
            n_tests++; if (outDemuxSel !== 2'(i)) begin n_fail++; $display("FAIL full_sel%0d got %0d want %0d", i, outDemuxSel, i); end
            n_tests++; if (outDemuxData !== 4'(4'hA + i)) begin n_fail++; $display("FAIL full_data%0d got %h want %h", i, outDemuxData, 4'(4'hA + i)); end
            tick();
        end
        inSymbolValid = 1'b0;
        inWordReady   = 1'b1;
        #1;
        n_tests++; if (outWordValid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b want 1", outWordValid); end
        n_tests++; if (outWord !== 16'hABCD) begin n_fail++; $display("FAIL full_word got %h want abcd", outWord); end
        n_tests++; if (outWordMask !== 4'hF) begin n_fail++; $display("FAIL full_mask got %b want 1111", outWordMask); end
        n_tests++; if (outSymbolReady !== 1'b0) begin n_fail++; $display("FAIL full_hold_ready got %b want 0", outSymbolReady); end
        // Back-to-back: a new frame must start straight from HOLD and take 5 cycles per word
        cnt = 0;
        got = 1'b0;
        inSymbolValid = 1'b1;
        while (cnt < 20 && !got) begin
            inSymbol = 4'(cnt + 5);
            tick();
            cnt++;
            if (cnt == 1) begin
                n_tests++; if (outSymbolReady !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle got ready %b want 1", outSymbolReady); end
            end
            if (outWordValid) got = 1'b1;
        end
        n_tests++; if (!got || cnt != 5) begin n_fail++; $display("FAIL b2b_period got %0d cycles (seen %b) want 5", cnt, got); end
        n_tests++; if (outWord !== 16'h6789) begin n_fail++; $display("FAIL b2b_word got %h want 6789", outWord); end
        inSymbolValid = 1'b0;
    endtask

    task automatic test_sparse_lanes();
        do_reset();
        inLaneEnable = 4'b1010;
        tick();
        inLaneEnable  = 4'b1111;
        inSymbol      = 4'h5;
        inSymbolValid = 1'b1;
        #1;
        n_tests++; if (outDemuxSel !== 2'd1) begin n_fail++; $display("FAIL sparse_sel_a got %0d want 1", outDemuxSel); end
        tick();
        inSymbol = 4'h9;
        #1;
        n_tests++; if (outDemuxSel !== 2'd3) begin n_fail++; $display("FAIL sparse_sel_b got %0d want 3", outDemuxSel); end
        tick();
        inSymbolValid = 1'b0;
        #1;
        n_tests++; if (outWordValid !== 1'b1) begin n_fail++; $display("FAIL sparse_valid got %b want 1", outWordValid); end
        n_tests++; if (outWord !== 16'h0509) begin n_fail++; $display("FAIL sparse_word got %h want 0509", outWord); end
        n_tests++; if (outWordMask !== 4'b1010) begin n_fail++; $display("FAIL sparse_mask got %b want 1010", outWordMask); end
    endtask

    task automatic test_timeout();
        int cnt;
        bit got;
        do_reset();
        inLaneEnable = 4'hF;
        tick();
        repeat (20) tick();
        n_tests++; if (outSymbolReady !== 1'b1 || outWordValid !== 1'b0) begin n_fail++; $display("FAIL empty_no_timeout got ready %b valid %b want 1 0", outSymbolReady, outWordValid); end
        inSymbol      = 4'h7;
        inSymbolValid = 1'b1;
        tick();
        inSymbolValid = 1'b0;
        cnt = 0;
        got = 1'b0;
        while (cnt < 40 && !got) begin
            tick();
            cnt++;
            if (outWordValid) got = 1'b1;
        end
        n_tests++; if (!got || cnt != TO) begin n_fail++; $display("FAIL timeout_cycles got %0d (seen %b) want %0d", cnt, got, TO); end
        n_tests++; if (outWord !== 16'h7000) begin n_fail++; $display("FAIL timeout_word got %h want 7000", outWord); end
        n_tests++; if (outWordMask !== 4'b0001) begin n_fail++; $display("FAIL timeout_mask got %b want 0001", outWordMask); end
    endtask

    task automatic test_flush();
        do_reset();
        inLaneEnable = 4'hF;
        tick();
        inFlush = 1'b1;
        tick();
        inFlush = 1'b0;
        #1;
        n_tests++; if (outSymbolReady !== 1'b1 || outWordValid !== 1'b0) begin n_fail++; $display("FAIL empty_flush got ready %b valid %b want 1 0", outSymbolReady, outWordValid); end
        for (int i = 1; i <= 3; i++) begin
            inSymbol      = 4'(i);
            inSymbolValid = 1'b1;
            inFlush       = (i == 3);
            tick();
        end
        inSymbolValid = 1'b0;
        inFlush       = 1'b0;
        #1;
        n_tests++; if (outWordValid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got %b want 1", outWordValid); end
        n_tests++; if (outWord !== 16'h1230) begin n_fail++; $display("FAIL flush_word got %h want 1230", outWord); end
        n_tests++; if (outWordMask !== 4'b0111) begin n_fail++; $display("FAIL flush_mask got %b want 0111", outWordMask); end
    endtask

    task automatic test_hold_stall();
        do_reset();
        inLaneEnable = 4'hF;
        tick();
        for (int i = 0; i < 4; i++) begin
            inSymbol      = 4'(4'hA + i);
            inSymbolValid = 1'b1;
            tick();
        end
        inSymbol = 4'h3;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_tests++; if (outWord !== 16'hABCD || outWordMask !== 4'hF) begin n_fail++; $display("FAIL stall_word c%0d got %h/%b want abcd/1111", c, outWord, outWordMask); end
            n_tests++; if (outSymbolReady !== 1'b0 || outWordValid !== 1'b1) begin n_fail++; $display("FAIL stall_hs c%0d got ready %b valid %b want 0 1", c, outSymbolReady, outWordValid); end
            n_tests++; if (outDemuxData !== 4'd0) begin n_fail++; $display("FAIL stall_data c%0d got %h want 0", c, outDemuxData); end
            tick();
        end
        inSymbolValid = 1'b0;
        inLaneEnable  = 4'd0;
        inWordReady   = 1'b1;
        tick();
        tick();
        n_tests++; if (outWordValid !== 1'b0 || outSymbolReady !== 1'b0 || outWord !== 16'h0) begin n_fail++; $display("FAIL hold_to_idle got valid %b ready %b word %h want 0 0 0000", outWordValid, outSymbolReady, outWord); end
    endtask

    task automatic test_reset_midframe();
        bit seen;
        do_reset();
        inLaneEnable = 4'hF;
        tick();
        inSymbolValid = 1'b1;
        inSymbol      = 4'h4;
        tick();
        inSymbol      = 4'h6;
        tick();
        inResetN = 1'b0;
        #1;
        n_tests++; if ({outSymbolReady, outWordValid, outWord, outWordMask, outDemuxSel, outDemuxData} !== 28'd0) begin
            n_fail++; $display("FAIL midreset_outputs got r%b v%b w%h m%b s%0d d%h want all 0", outSymbolReady, outWordValid, outWord, outWordMask, outDemuxSel, outDemuxData);
        end
        tick();
        inLaneEnable  = 4'd0;
        inSymbolValid = 1'b0;
        inResetN      = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (outWordValid || outSymbolReady) seen = 1'b1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL midreset_idle got activity %b want 0", seen); end
    endtask

    task automatic model_start(input logic [3:0] en);
        m_lanes.delete();
        for (int k = 0; k < 4; k++) begin
            if (en[k]) m_lanes.push_back(k);
            m_sym[k] = 4'd0;
            m_wr[k]  = 1'b0;
        end
        m_pos   = 0;
        m_idle  = 0;
        m_phase = 1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            m_sym[k] = 4'd0;
            m_wr[k]  = 1'b0;
        end
        m_idle  = 0;
        m_phase = 0;
    endtask

    task automatic test_random();
        int          rate;
        int          lane;
        bit          acc;
        bit          any_wr;
        logic [15:0] exp_word;
        logic [3:0]  exp_mask;
        do_reset();
        model_clear();
        rate = 50;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (cyc % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rate = 5;
                    1:       rate = 50;
                    default: rate = 95;
                endcase
            end
            inSymbol      = 4'($urandom_range(0, 15));
            inSymbolValid = ($urandom_range(0, 99) < rate);
            inFlush       = ($urandom_range(0, 99) < 4);
            inWordReady   = ($urandom_range(0, 99) < 60);
            inLaneEnable  = 4'($urandom_range(0, 15));
            #1;
            exp_word = 16'd0;
            exp_mask = 4'd0;
            any_wr   = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (m_wr[k]) exp_word[15 - 4 * k -: 4] = m_sym[k];
                exp_mask[k] = m_wr[k];
                if (m_wr[k]) any_wr = 1'b1;
            end
            acc = (m_phase == 1) && inSymbolValid;
            n_tests++; if (outSymbolReady !== (m_phase == 1)) begin n_fail++; $display("FAIL rnd_ready cyc%0d got %b want %b", cyc, outSymbolReady, (m_phase == 1)); end
            n_tests++; if (outWordValid !== (m_phase == 2)) begin n_fail++; $display("FAIL rnd_valid cyc%0d got %b want %b", cyc, outWordValid, (m_phase == 2)); end
            n_tests++; if (outWord !== exp_word || outWordMask !== exp_mask) begin n_fail++; $display("FAIL rnd_word cyc%0d got %h/%b want %h/%b", cyc, outWord, outWordMask, exp_word, exp_mask); end
            if (acc) begin
                lane = m_lanes[m_pos];
                n_tests++; if (outDemuxSel !== 2'(lane) || outDemuxData !== inSymbol) begin n_fail++; $display("FAIL rnd_demux cyc%0d got %0d/%h want %0d/%h", cyc, outDemuxSel, outDemuxData, lane, inSymbol); end
            end else begin
                n_tests++; if (outDemuxData !== 4'd0) begin n_fail++; $display("FAIL rnd_data_idle cyc%0d got %h want 0", cyc, outDemuxData); end
            end
            case (m_phase)
                0: begin
                    if (inLaneEnable != 4'd0) model_start(inLaneEnable);
                end
                1: begin
                    if (acc) begin
                        lane        = m_lanes[m_pos];
                        m_sym[lane] = inSymbol;
                        m_wr[lane]  = 1'b1;
                        m_idle      = 0;
                        m_pos++;
                        if (m_pos == m_lanes.size() || inFlush) m_phase = 2;
                    end else if (any_wr) begin
                        if (inFlush) begin
                            m_phase = 2;
                        end else begin
                            m_idle++;
                            if (m_idle >= TO) m_phase = 2;
                        end
                    end
                end
                default: begin
                    if (inWordReady) begin
                        model_clear();
                        if (inLaneEnable != 4'd0) model_start(inLaneEnable);
                    end
                end
            endcase
            tick();
        end
        inSymbolValid = 1'b0;
        inFlush       = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_sparse_lanes();
        test_timeout();
        test_flush();
        test_hold_stall();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
